move_input_ctrl: RTL and testbench

Player-input front end that sits directly upstream of gameController. It takes raw push-button levels (four cursor directions plus select) and synchronises and debounces them. It keeps a 3x3 cursor and issues a single-cycle playerWrite strobe with playerInput set to the selected cell address. Moves into occupied cells, or moves made after the game is over, are rejected locally and never reach gameController.

---
 rtl/move_input_ctrl.sv | 150 +++++++++++++++
 tb/tb_move_input_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/move_input_ctrl.sv
// Player-input front end: synchronises and debounces buttons, moves a 3x3 cursor, and issues moves to gameController.
// Optional CURSOR_WRAP_EN: cursor wraps at the board edges instead of saturating.
module move_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btnUp,
    input  logic        btnDown,
    input  logic        btnLeft,
    input  logic        btnRight,
    input  logic        btnSel,
    input  logic [17:0] gBoard,
    input  logic        gameIsDone,
    output logic        playerWrite,
    output logic [3:0]  playerInput,
    output logic [3:0]  cursor,
    output logic        moveReject
);

    localparam int unsigned NBTN   = 5;
    localparam int unsigned CELL_W = 4;
    localparam int unsigned POS_W  = 2;
    localparam int unsigned B_SEL  = 4;
    localparam int unsigned B_UP   = 3;
    localparam int unsigned B_DOWN = 2;
    localparam int unsigned B_LEFT = 1;
    localparam int unsigned B_RGHT = 0;

`ifdef CURSOR_WRAP_EN
    localparam logic [POS_W-1:0] DEC_EDGE = 2'd2;
    localparam logic [POS_W-1:0] INC_EDGE = 2'd0;
`else
    localparam logic [POS_W-1:0] DEC_EDGE = 2'd0;
    localparam logic [POS_W-1:0] INC_EDGE = 2'd2;
`endif

    typedef enum logic [1:0] {READY, WRITE, HOLD} state_e;

    state_e              state_q, state_d;
    logic [NBTN-1:0]     btn_raw;
    logic [NBTN-1:0]     sync1_q, sync2_q;
    logic [NBTN-1:0]     deb_q, deb_d, deb_prev_q;
    logic [NBTN-1:0]     press;
    logic [CNT_W-1:0]    cnt_q [NBTN];
    logic [CNT_W-1:0]    cnt_d [NBTN];
    logic [POS_W-1:0]    row_q, row_d, col_q, col_d;
    logic [CELL_W-1:0]   cursor_q, cursor_d;
    logic [CELL_W-1:0]   input_q, input_d;
    logic                write_q, write_d;
    logic                reject_q, reject_d;
    logic                occupied;

    assign btn_raw  = {btnSel, btnUp, btnDown, btnLeft, btnRight};
    assign press    = deb_q & ~deb_prev_q;
    assign occupied = |gBoard[{cursor_q, 1'b0} +: 2];

    // Debounce: level follows the synchroniser only after a stable run of DEBOUNCE_CYCLES.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < int'(NBTN); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        input_d  = input_q;
        write_d  = 1'b0;
        reject_d = 1'b0;
        case (state_q)
            READY: begin
                if (press[B_SEL]) begin
                    if (gameIsDone || occupied) begin
                        reject_d = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        write_d = 1'b1;
                        input_d = cursor_q;
                        state_d = WRITE;
                    end
                end else if (press[B_UP]) begin
                    row_d = (row_q == 2'd0) ? DEC_EDGE : row_q - 2'd1;
                end else if (press[B_DOWN]) begin
                    row_d = (row_q == 2'd2) ? INC_EDGE : row_q + 2'd1;
                end else if (press[B_LEFT]) begin
                    col_d = (col_q == 2'd0) ? DEC_EDGE : col_q - 2'd1;
                end else if (press[B_RGHT]) begin
                    col_d = (col_q == 2'd2) ? INC_EDGE : col_q + 2'd1;
                end
            end
            WRITE:   state_d = HOLD;
            HOLD:    if (!deb_q[B_SEL]) state_d = READY;
            default: state_d = READY;
        endcase
        cursor_d = CELL_W'({row_d, 1'b0}) + CELL_W'(row_d) + CELL_W'(col_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= READY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < int'(NBTN); i++) cnt_q[i] <= '0;
            row_q      <= '0;
            col_q      <= '0;
            cursor_q   <= '0;
            input_q    <= '0;
            write_q    <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < int'(NBTN); i++) cnt_q[i] <= cnt_d[i];
            row_q      <= row_d;
            col_q      <= col_d;
            cursor_q   <= cursor_d;
            input_q    <= input_d;
            write_q    <= write_d;
            reject_q   <= reject_d;
        end
    end

    assign playerWrite = write_q;
    assign playerInput = input_q;
    assign cursor      = cursor_q;
    assign moveReject  = reject_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Directed self-checking bench for move_input_ctrl (DEBOUNCE_CYCLES=4); honours CURSOR_WRAP_EN for edge expectations.
module tb_move_input_ctrl;

    localparam logic [4:0] M_SEL   = 5'b10000;
    localparam logic [4:0] M_UP    = 5'b01000;
    localparam logic [4:0] M_DOWN  = 5'b00100;
    localparam logic [4:0] M_LEFT  = 5'b00010;
    localparam logic [4:0] M_RIGHT = 5'b00001;

    logic        clk = 1'b0;
    logic        reset;
    logic        btnUp, btnDown, btnLeft, btnRight, btnSel;
    logic [17:0] gBoard;
    logic        gameIsDone;
    logic        playerWrite;
    logic [3:0]  playerInput;
    logic [3:0]  cursor;
    logic        moveReject;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt, rej_cnt, viol;
    logic prev_wr, prev_rej;
    logic [3:0] last_pin;

    move_input_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .btnUp      (btnUp),
        .btnDown    (btnDown),
        .btnLeft    (btnLeft),
        .btnRight   (btnRight),
        .btnSel     (btnSel),
        .gBoard     (gBoard),
        .gameIsDone (gameIsDone),
        .playerWrite(playerWrite),
        .playerInput(playerInput),
        .cursor     (cursor),
        .moveReject (moveReject)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_counts();
        wr_cnt = 0; rej_cnt = 0; viol = 0;
    endtask

    // Advance n cycles, sampling on the falling edge and tallying strobes.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (playerWrite) begin wr_cnt++; last_pin = playerInput; end
            if (moveReject) rej_cnt++;
            if (playerWrite && moveReject) viol++;
            if (playerWrite && prev_wr) viol++;
            if (moveReject && prev_rej) viol++;
            prev_wr  = playerWrite;
            prev_rej = moveReject;
        end
    endtask

    task automatic press(input logic [4:0] mask, input int hold, input int rel);
        {btnSel, btnUp, btnDown, btnLeft, btnRight} = mask;
        step(hold);
        {btnSel, btnUp, btnDown, btnLeft, btnRight} = 5'b0;
        step(rel);
    endtask

    initial begin
        reset = 1'b0;
        {btnSel, btnUp, btnDown, btnLeft, btnRight} = 5'b0;
        gBoard = '0; gameIsDone = 1'b0;
        prev_wr = 1'b0; prev_rej = 1'b0; last_pin = '0;
        clear_counts();

        repeat (3) @(negedge clk);
        check("rst_cursor", 32'(cursor), 32'd0);
        check("rst_write", 32'(playerWrite), 32'd0);
        check("rst_reject", 32'(moveReject), 32'd0);
        check("rst_pin", 32'(playerInput), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_cursor", 32'(cursor), 32'd0);
            check("idle_write", 32'(playerWrite), 32'd0);
            check("idle_reject", 32'(moveReject), 32'd0);
        end

        press(M_RIGHT, 10, 10);
        check("right1", 32'(cursor), 32'd1);
        press(M_RIGHT, 10, 10);
        check("right2", 32'(cursor), 32'd2);
        press(M_DOWN, 10, 10);
        check("down", 32'(cursor), 32'd5);

        // Strobe must appear exactly 7 edges after the first edge sampling Sel.
        clear_counts();
        btnSel = 1'b1;
        step(6);
        check("lat_pre", 32'(playerWrite), 32'd0);
        step(1);
        check("lat_write", 32'(playerWrite), 32'd1);
        check("lat_pin", 32'(playerInput), 32'd5);
        step(1);
        check("lat_post", 32'(playerWrite), 32'd0);
        step(2);
        btnSel = 1'b0;
        step(10);
        check("sel1_wr_cnt", 32'(wr_cnt), 32'd1);
        check("sel1_pin_hold", 32'(playerInput), 32'd5);

        clear_counts();
        gBoard = 18'h0;
        gBoard[11:10] = 2'b10;
        press(M_SEL, 10, 10);
        check("occ_rej_cnt", 32'(rej_cnt), 32'd1);
        check("occ_wr_cnt", 32'(wr_cnt), 32'd0);

        clear_counts();
        gBoard = '0; gameIsDone = 1'b1;
        press(M_SEL, 10, 10);
        check("done_rej_cnt", 32'(rej_cnt), 32'd1);
        check("done_wr_cnt", 32'(wr_cnt), 32'd0);
        gameIsDone = 1'b0;

        clear_counts();
        press(M_SEL, 50, 10);
        check("hold_wr_cnt", 32'(wr_cnt), 32'd1);
        press(M_SEL, 10, 10);
        check("second_wr_cnt", 32'(wr_cnt), 32'd2);
        check("second_pin", 32'(last_pin), 32'd5);
        check("rej_none", 32'(rej_cnt), 32'd0);
        check("no_overlap", 32'(viol), 32'd0);

        press(M_RIGHT, 2, 10);
        check("glitch2", 32'(cursor), 32'd5);
        press(M_RIGHT, 3, 10);
        check("glitch3", 32'(cursor), 32'd5);
        press(M_LEFT, 10, 10);
        check("left_to4", 32'(cursor), 32'd4);
        press(M_UP | M_LEFT, 10, 10);
        check("up_left_prio", 32'(cursor), 32'd1);
        press(M_LEFT, 10, 10);
        check("left_to0", 32'(cursor), 32'd0);

        clear_counts();
        press(M_LEFT, 10, 10);
`ifdef CURSOR_WRAP_EN
        check("left_edge", 32'(cursor), 32'd2);
        press(M_UP, 10, 10);
        check("up_edge", 32'(cursor), 32'd8);
        press(M_DOWN, 10, 10);
        check("down_edge", 32'(cursor), 32'd2);
`else
        check("left_edge", 32'(cursor), 32'd0);
        press(M_UP, 10, 10);
        check("up_edge", 32'(cursor), 32'd0);
        press(M_DOWN, 10, 10);
        check("down_mid", 32'(cursor), 32'd3);
`endif
        check("edge_no_rej", 32'(rej_cnt), 32'd0);

        // Asynchronous reset landing in the WRITE cycle.
        btnSel = 1'b1;
        step(6);
        step(1);
        check("wr_before_rst", 32'(playerWrite), 32'd1);
        #2;
        reset = 1'b0;
        btnSel = 1'b0;
        #1;
        check("rst_async_wr", 32'(playerWrite), 32'd0);
        check("rst_async_cursor", 32'(cursor), 32'd0);
        check("rst_async_pin", 32'(playerInput), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        clear_counts();
        step(15);
        check("post_rst_wr_cnt", 32'(wr_cnt), 32'd0);
        check("post_rst_cursor", 32'(cursor), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
